conv_frame_encoder: RTL and testbench
=====================================

Name: conv_frame_encoder

Overview:
- Frame-level convolutional encoder. It is the transmit side feeding the decoder's i_decoder_data_frame input.
- Accepts one DATA_FRAME_LENGTH-bit data word per handshake. Encodes it one bit per cycle, rate 1/2, with K selectable 3 or 5.
- Appends MAX_CONSTRAINT_LENGTH-1 zero tail steps so the trellis terminates in state 0.
- Presents the packed TRACEBACK_DEPTH-bit coded frame on a valid/ready output.

Parameters:
- DATA_FRAME_LENGTH, 8, data bits per frame
- MAX_CONSTRAINT_LENGTH, 5, largest K; tail length is MAX_CONSTRAINT_LENGTH-1
- MAX_CODE_RATE, 2, coded bits per step
- TRACEBACK_DEPTH, 24, coded frame width = MAX_CODE_RATE*(DATA_FRAME_LENGTH+MAX_CONSTRAINT_LENGTH-1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_mode_sel  in  1  0: K=3 (g0=111, g1=101); 1: K=5 (g0=10011, g1=11101)
- i_data  in  DATA_FRAME_LENGTH  data word; MSB encoded first
- i_valid  in  1  input word valid
- o_ready  out  1  encoder can accept a word
- o_frame  out  TRACEBACK_DEPTH  packed coded frame
- o_valid  out  1  o_frame valid
- i_ready  in  1  downstream accepts frame
- o_busy  out  1  high while in ENCODE

Behaviour:
- Reset (rst=0, async, any state): FSM=IDLE, o_ready=1, o_valid=0, o_busy=0, o_frame=0, shift register=0, step counter=0.
- FSM states IDLE, ENCODE, HOLD.
- IDLE: o_ready=1. On an edge with i_valid=1:
  - latch i_data and i_mode_sel; clear encoder state and counter
  - go to ENCODE; o_ready=0
- ENCODE, per edge (step k = 0..11):
  - u = data MSB-first for k<8, else 0
  - g0/g1 output bits are the XOR of the generator taps over {u,s1,..,s(K-1)}; generator MSB taps u
  - write {g0,g1} to o_frame[TRACEBACK_DEPTH-1-2k -: 2]
  - shift u into the state register
  - K=3 uses only s1,s2; unused state bits are held 0
- Step 11 edge: go to HOLD, o_valid=1, o_busy=0.
- Latency: o_valid rises exactly 12 edges after the acceptance edge.
- HOLD: o_frame stable, o_valid=1. On an edge with i_ready=1: o_valid=0, go to IDLE, o_ready=1.
  - A new word may be accepted no earlier than the edge after that.
- Input handling outside IDLE:
  - i_valid outside IDLE is ignored, not queued.
  - i_mode_sel changes after acceptance have no effect on the current frame.
- For K=3 the extra tail steps encode zeros from state 0 and emit 00.
- Throughput: one frame per 14 cycles minimum (1 accept + 12 encode + 1 handshake).

Optional Feature:
- Macro: ERR_INJECT_EN.
- Defined:
  - adds input i_err_mask[TRACEBACK_DEPTH-1:0], sampled at the acceptance edge
  - o_frame = encoded frame XOR latched mask, for decoder BER/correction testing
  - the mask is reset to 0
- Undefined: no port, no XOR, o_frame is the clean codeword.

Decomposition:
- The existing shared define file holds DATA_FRAME_LENGTH, MAX_CONSTRAINT_LENGTH, MAX_CODE_RATE, TRACEBACK_DEPTH, and the generator polynomial constants for both modes. This keeps encoder and decoder consistent.
- One sub-module: conv_step_enc. It is combinational: (u, state, mode) -> {g0,g1}, next state.
- FSM, counter and frame packing stay in the parent.

Test Plan:
- Reset: hold rst=0 two cycles -> o_ready=1, o_valid=0, o_frame=0. Assert rst low mid-ENCODE -> same values immediately, with no clock edge.
- K=3 (mode 0), i_data=8'b1011_0000 -> o_valid 12 edges after accept, o_frame=24'hE17000.
- K=5 (mode 1), i_data=8'h80 -> o_frame=24'hD6C000 (impulse response 11,01,01,10,11, then zeros).
- Backpressure: i_ready=0 for 10 cycles in HOLD; toggle i_valid and i_data meanwhile:
  - o_frame stays stable and o_ready=0
  - on release, one handshake occurs, then IDLE
  - the next word is encoded correctly with no state leakage from the previous frame
- Mode latch: accept with mode 0, flip i_mode_sel to 1 during ENCODE -> result matches the K=3 golden model.
- ERR_INJECT_EN built: i_err_mask=24'h000001 with K=3 vector above -> o_frame=24'hE17001. Built without the macro: port absent, clean frame.

Source files
------------

// File: rtl/conv_frame_encoder_pkg.sv
// Shared constants for the convolutional frame encoder and its matching decoder.
// Frame geometry, generator polynomials for both modes, and the FSM encoding.
package conv_frame_encoder_pkg;

   localparam int DATA_FRAME_LENGTH     = 8;
   localparam int MAX_CONSTRAINT_LENGTH = 5;
   localparam int MAX_CODE_RATE         = 2;
   localparam int TRACEBACK_DEPTH       =
      MAX_CODE_RATE * (DATA_FRAME_LENGTH + MAX_CONSTRAINT_LENGTH - 1);

   localparam int ST_W  = MAX_CONSTRAINT_LENGTH - 1;
   localparam int STEPS = DATA_FRAME_LENGTH + MAX_CONSTRAINT_LENGTH - 1;
   localparam int CNT_W = $clog2(STEPS);

   // Generator MSB taps the input bit u, following bits tap s1, s2, ...
   localparam logic [2:0] G0_K3 = 3'b111;
   localparam logic [2:0] G1_K3 = 3'b101;
   localparam logic [4:0] G0_K5 = 5'b10011;
   localparam logic [4:0] G1_K5 = 5'b11101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENCODE,
      S_HOLD
   } enc_state_e;

endpackage

// File: rtl/conv_frame_encoder_step_enc.sv
// One trellis step: (u, state, mode) -> {g0,g1} and next state.
// State bit ST_W-1 is s1 (newest), bit 0 is s4 (oldest).
module conv_step_enc
   import conv_frame_encoder_pkg::*;
(
   input  logic            u,
   input  logic [ST_W-1:0] st,
   input  logic            mode,
   output logic [1:0]      g,
   output logic [ST_W-1:0] nst
);

   logic [4:0] win5;
   logic [2:0] win3;

   assign win5 = {u, st};
   assign win3 = {u, st[ST_W-1 -: 2]};

   always_comb begin
      g   = '0;
      nst = '0;
      if (mode) begin
         g   = {^(win5 & G0_K5), ^(win5 & G1_K5)};
         nst = {u, st[ST_W-1:1]};
      end else begin
         // K=3 keeps s3/s4 at zero
         g   = {^(win3 & G0_K3), ^(win3 & G1_K3)};
         nst = {u, st[ST_W-1], {(ST_W-2){1'b0}}};
      end
   end

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame-level rate-1/2 convolutional encoder, K=3 or K=5, zero-tail terminated.
// Optional macro ERR_INJECT_EN adds i_err_mask, XORed onto the output frame.
module conv_frame_encoder
   import conv_frame_encoder_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_mode_sel,
   input  logic [DATA_FRAME_LENGTH-1:0] i_data,
   input  logic                         i_valid,
   output logic                         o_ready,
   output logic [TRACEBACK_DEPTH-1:0]   o_frame,
   output logic                         o_valid,
   input  logic                         i_ready,
`ifdef ERR_INJECT_EN
   input  logic [TRACEBACK_DEPTH-1:0]   i_err_mask,
`endif
   output logic                         o_busy
);

   enc_state_e                   state_q, state_d;
   logic [DATA_FRAME_LENGTH-1:0] data_q, data_d;
   logic                         mode_q, mode_d;
   logic [ST_W-1:0]              st_q, st_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [TRACEBACK_DEPTH-1:0]   frame_q, frame_d;
   logic [1:0]                   g;
   logic [ST_W-1:0]              nst;

   // Data shifts left each step, so it reads zero during the tail
   conv_step_enc u_step (
      .u    (data_q[DATA_FRAME_LENGTH-1]),
      .st   (st_q),
      .mode (mode_q),
      .g    (g),
      .nst  (nst)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         mode_q  <= 1'b0;
         st_q    <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      st_d    = st_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               data_d  = i_data;
               mode_d  = i_mode_sel;
               st_d    = '0;
               cnt_d   = '0;
               frame_d = '0;
               state_d = S_ENCODE;
            end
         end
         S_ENCODE: begin
            data_d  = {data_q[DATA_FRAME_LENGTH-2:0], 1'b0};
            st_d    = nst;
            frame_d = {frame_q[TRACEBACK_DEPTH-3:0], g};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_busy  = (state_q == S_ENCODE);
   assign o_valid = (state_q == S_HOLD);

`ifdef ERR_INJECT_EN
   logic [TRACEBACK_DEPTH-1:0] mask_q, mask_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

   always_comb begin
      mask_d = mask_q;
      if (state_q == S_IDLE && i_valid) begin
         mask_d = i_err_mask;
      end
   end

   assign o_frame = frame_q ^ mask_q;
`else
   assign o_frame = frame_q;
`endif

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed plus randomized bench for conv_frame_encoder against a
// bit-history reference model of the convolutional code.
module tb_conv_frame_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_mode_sel = 1'b0;
   logic [7:0]  i_data = '0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [23:0] o_frame;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic        o_busy;
`ifdef ERR_INJECT_EN
   logic [23:0] i_err_mask = '0;
`endif

   int vectors = 0;
   int errs = 0;

   always #5 clk = ~clk;

   conv_frame_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .i_mode_sel (i_mode_sel),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_frame    (o_frame),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
`ifdef ERR_INJECT_EN
      .i_err_mask (i_err_mask),
`endif
      .o_busy     (o_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output bit j of step k = XOR over taps i of poly[K-1-i] * u[k-i]
   function automatic logic [23:0] model(input logic [7:0] d,
                                          input logic m);
      logic [23:0] f;
      logic [4:0]  p0, p1;
      logic        u [0:11];
      logic        a, b, h;
      int          kk;
      f  = '0;
      kk = m ? 5 : 3;
      p0 = m ? 5'b10011 : 5'b00111;
      p1 = m ? 5'b11101 : 5'b00101;
      for (int k = 0; k < 12; k++) u[k] = (k < 8) ? d[7-k] : 1'b0;
      for (int k = 0; k < 12; k++) begin
         a = 1'b0;
         b = 1'b0;
         for (int i = 0; i < kk; i++) begin
            h = (k - i >= 0) ? u[k-i] : 1'b0;
            a = a ^ (p0[kk-1-i] & h);
            b = b ^ (p1[kk-1-i] & h);
         end
         f[23-2*k] = a;
         f[22-2*k] = b;
      end
      return f;
   endfunction

   // Accept one word, count edges to o_valid, check frame, then handshake
   task automatic run_frame(input string tag, input logic [7:0] d,
                            input logic m, input logic [23:0] exp,
                            input logic flip_mode);
      int n;
      n = 0;
      while (!o_ready && n < 30) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_ready"}, o_ready, 1'b1);
      i_data = d;
      i_mode_sel = m;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      if (flip_mode) i_mode_sel = ~m;
      i_data = ~d;
      n = 0;
      while (!o_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_latency"}, n, 12);
      check({tag, "_frame"}, o_frame, exp);
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      check({tag, "_done"}, {o_valid, o_ready}, 2'b01);
   endtask

   initial begin
      logic [23:0] hold_frame;
      logic [23:0] mask;
      logic [7:0]  rd;
      logic        rm;

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", o_ready, 1'b1);
      check("rst_valid", o_valid, 1'b0);
      check("rst_busy",  o_busy,  1'b0);
      check("rst_frame", o_frame, 24'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      check("gold_k3_model", model(8'b1011_0000, 1'b0), 24'hE17000);
      check("gold_k5_model", model(8'h80, 1'b1), 24'hD6C000);
      run_frame("k3", 8'b1011_0000, 1'b0, 24'hE17000, 1'b0);
      run_frame("k5", 8'h80, 1'b1, 24'hD6C000, 1'b0);

      // Backpressure in HOLD with noisy inputs
      i_data = 8'h5A;
      i_mode_sel = 1'b1;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("bp_valid", o_valid, 1'b1);
      check("bp_frame", o_frame, model(8'h5A, 1'b1));
      hold_frame = o_frame;
      for (int c = 0; c < 10; c++) begin
         i_valid = c[0];
         i_data = 8'($urandom);
         i_mode_sel = c[1];
         @(posedge clk); #1;
         check("bp_stable", o_frame, hold_frame);
         check("bp_hold", {o_valid, o_ready}, 2'b10);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      check("bp_release", {o_valid, o_ready, o_busy}, 3'b010);
      run_frame("bp_next", 8'h3C, 1'b0, model(8'h3C, 1'b0), 1'b0);

      run_frame("mode_latch", 8'hC9, 1'b0, model(8'hC9, 1'b0), 1'b1);

`ifdef ERR_INJECT_EN
      i_err_mask = 24'h000001;
      i_data = 8'b1011_0000;
      i_mode_sel = 1'b0;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_err_mask = 24'hFFFFFF;
      repeat (12) @(posedge clk);
      #1;
      check("err_frame", o_frame, 24'hE17001);
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
`endif

      for (int r = 0; r < 20; r++) begin
         rd = 8'($urandom);
         rm = 1'($urandom);
         mask = 24'h0;
`ifdef ERR_INJECT_EN
         mask = 24'($urandom);
         i_err_mask = mask;
`endif
         run_frame("rand", rd, rm, model(rd, rm) ^ mask, r[0]);
      end
`ifdef ERR_INJECT_EN
      i_err_mask = '0;
`endif

      // Async reset mid-ENCODE, no clock edge between assert and check
      i_data = 8'hFF;
      i_mode_sel = 1'b1;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_busy", o_busy, 1'b1);
      #1 rst = 1'b0;
      #1;
      check("arst_ready", o_ready, 1'b1);
      check("arst_valid", o_valid, 1'b0);
      check("arst_busy",  o_busy,  1'b0);
      check("arst_frame", o_frame, 24'h0);
      @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;
      run_frame("post_rst", 8'h81, 1'b1, model(8'h81, 1'b1), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
